// File: rtl/k_rptr_empty_pkg.sv
// k_rptr_empty_pkg: pointer width and Gray/binary helpers shared by the FIFO read and write sides
package k_rptr_empty_pkg;
  localparam int max_w = 32;
  function automatic int ptr_w(input int a_size);
    return a_size + 1;
  endfunction
  function automatic logic [max_w-1:0] b2g(input logic [max_w-1:0] b);
    return b ^ (b >> 1);
  endfunction
  // Zero-extended inputs are safe: leading zeros leave the prefix XOR unchanged
  function automatic logic [max_w-1:0] g2b(input logic [max_w-1:0] g);
    logic [max_w-1:0] b;
    b = g;
    for (int i = 1; i < max_w; i++) b ^= g >> i;
    return b;
  endfunction
endpackage

// File: rtl/k_rptr_empty_g2b.sv
// k_g2b_converter: combinational Gray-to-binary conversion
//   i_gray  Gray-coded input, size bits
//   o_bin   binary equivalent, size bits
module k_g2b_converter #(
  parameter int size = 5
) (
  input  logic [size-1:0] i_gray,
  output logic [size-1:0] o_bin
);
  // Each binary bit is the XOR of its own Gray bit and every Gray bit above it
  for (genvar i = 0; i < size; i++) begin : g_bit
    assign o_bin[i] = ^i_gray[size-1:i];
  end
endmodule

// File: rtl/k_rptr_empty.sv
// k_rptr_empty: dual-clock FIFO read pointer, empty/almost-empty/level/underflow flags
//   i_clk           read-domain clock
//   i_rst_n         asynchronous active-low reset
//   i_inc           read request, accepted only while o_empty=0
//   i_wptr          Gray write pointer from the write domain (asynchronous)
//   o_ptr           registered Gray read pointer to the write domain
//   o_addr          RAM read address
//   o_empty         registered empty flag
//   o_almost_empty  registered, level <= ae_thresh
//   o_level         registered occupancy seen by the read domain
//   o_underflow     one-cycle pulse when i_inc arrives while empty
module k_rptr_empty
  import k_rptr_empty_pkg::*;
#(
  parameter int addr_size = 4,
  parameter int ae_thresh = 2
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_inc,
  input  logic [addr_size:0]   i_wptr,
  output logic [addr_size:0]   o_ptr,
  output logic [addr_size-1:0] o_addr,
  output logic                 o_empty,
  output logic                 o_almost_empty,
  output logic [addr_size:0]   o_level,
  output logic                 o_underflow
);
  localparam int pw = ptr_w(addr_size);
  localparam logic [pw-1:0] ae_lim = pw'(ae_thresh);
  // Two-flop synchronizer on the incoming Gray pointer; named for CDC constraints
  logic [pw-1:0] r_wq1_sync, r_wq2_sync;
  logic [pw-1:0] r_bin, r_ptr, r_level;
  logic          r_empty, r_almost_empty, r_underflow;
  logic          w_rd_en;
  logic [pw-1:0] w_bnxt, w_gnxt, w_wbin, w_lvl;
  assign w_rd_en = i_inc & ~r_empty;
  assign w_bnxt  = r_bin + pw'(w_rd_en);
  assign w_gnxt  = w_bnxt ^ (w_bnxt >> 1);
  // Wraps modulo 2^pw, so a full FIFO (pointers differing only in the wrap bit) reads as 2^addr_size
  assign w_lvl   = w_wbin - w_bnxt;
  k_g2b_converter #(.size(pw)) u_g2b (
    .i_gray (r_wq2_sync),
    .o_bin  (w_wbin)
  );
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wq1_sync     <= '0;
      r_wq2_sync     <= '0;
      r_bin          <= '0;
      r_ptr          <= '0;
      r_empty        <= 1'b1;
      r_almost_empty <= 1'b1;
      r_level        <= '0;
      r_underflow    <= 1'b0;
    end else begin
      r_wq1_sync     <= i_wptr;
      r_wq2_sync     <= r_wq1_sync;
      r_bin          <= w_bnxt;
      r_ptr          <= w_gnxt;
      r_empty        <= (w_gnxt == r_wq2_sync);
      r_almost_empty <= (w_lvl <= ae_lim);
      r_level        <= w_lvl;
      r_underflow    <= i_inc & r_empty;
    end
  end
  assign o_ptr          = r_ptr;
  assign o_addr         = r_bin[addr_size-1:0];
  assign o_empty        = r_empty;
  assign o_almost_empty = r_almost_empty;
  assign o_level        = r_level;
  assign o_underflow    = r_underflow;
endmodule

// File: tb/tb_k_rptr_empty.sv
// tb_k_rptr_empty: directed self-checking bench for k_rptr_empty (addr_size=4, ae_thresh=2)
module tb_k_rptr_empty;
  logic       clk = 1'b0;
  logic       rst_n;
  logic       inc;
  logic [4:0] wptr;
  logic [4:0] ptr;
  logic [3:0] addr;
  logic       empty, almost_empty, underflow;
  logic [4:0] level;
  int n_cmp = 0;
  int n_bad = 0;
  logic [4:0] gtab [0:5] = '{5'b00000, 5'b00001, 5'b00011, 5'b00010, 5'b00110, 5'b00111};
  always #5 clk = ~clk;
  k_rptr_empty #(.addr_size(4), .ae_thresh(2)) dut (
    .i_clk          (clk),
    .i_rst_n        (rst_n),
    .i_inc          (inc),
    .i_wptr         (wptr),
    .o_ptr          (ptr),
    .o_addr         (addr),
    .o_empty        (empty),
    .o_almost_empty (almost_empty),
    .o_level        (level),
    .o_underflow    (underflow)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic chk_all(input string tag, input logic [4:0] e_ptr, input logic [3:0] e_addr,
                         input logic e_empty, input logic e_ae, input logic [4:0] e_level,
                         input logic e_uf);
    chk({tag, ".ptr"}, 32'(ptr), 32'(e_ptr));
    chk({tag, ".addr"}, 32'(addr), 32'(e_addr));
    chk({tag, ".empty"}, 32'(empty), 32'(e_empty));
    chk({tag, ".ae"}, 32'(almost_empty), 32'(e_ae));
    chk({tag, ".level"}, 32'(level), 32'(e_level));
    chk({tag, ".uf"}, 32'(underflow), 32'(e_uf));
  endtask
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  initial begin
    rst_n = 1'b0;
    inc   = 1'b0;
    wptr  = 5'b00011;
    tick(2);
    chk_all("rst", 5'b00000, 4'd0, 1, 1, 5'd0, 0);
    wptr  = 5'b00000;
    rst_n = 1'b1;
    tick(2);
    chk_all("idle", 5'b00000, 4'd0, 1, 1, 5'd0, 0);
    wptr = 5'b00001;
    tick(2);
    chk_all("arr2", 5'b00000, 4'd0, 1, 1, 5'd0, 0);
    tick(1);
    chk_all("arr3", 5'b00000, 4'd0, 0, 1, 5'd1, 0);
    wptr = 5'b00111;
    tick(3);
    chk_all("fill5", 5'b00000, 4'd0, 0, 0, 5'd5, 0);
    inc = 1'b1;
    for (int k = 0; k < 5; k++) begin
      chk_all("drain", gtab[k], 4'(k), 0, (5 - k) <= 2, 5'(5 - k), 0);
      tick(1);
    end
    chk_all("drained", 5'b00111, 4'd5, 1, 1, 5'd0, 0);
    tick(1);
    chk_all("uf1", 5'b00111, 4'd5, 1, 1, 5'd0, 1);
    tick(1);
    chk_all("uf2", 5'b00111, 4'd5, 1, 1, 5'd0, 1);
    inc = 1'b0;
    tick(1);
    chk_all("uf_end", 5'b00111, 4'd5, 1, 1, 5'd0, 0);
    wptr = 5'b01101;
    tick(3);
    chk_all("fill9", 5'b00111, 4'd5, 0, 0, 5'd4, 0);
    inc = 1'b1;
    tick(2);
    chk_all("mid", 5'b00100, 4'd7, 0, 1, 5'd2, 0);
    rst_n = 1'b0;
    #1;
    chk_all("async_rst", 5'b00000, 4'd0, 1, 1, 5'd0, 0);
    inc  = 1'b0;
    wptr = 5'b00000;
    tick(1);
    rst_n = 1'b1;
    wptr  = 5'b11000;
    tick(3);
    chk_all("full16", 5'b00000, 4'd0, 0, 0, 5'd16, 0);
    inc = 1'b1;
    for (int k = 0; k < 16; k++) begin
      chk("wrap.addr", 32'(addr), 32'(k));
      chk("wrap.level", 32'(level), 32'(16 - k));
      tick(1);
    end
    chk_all("wrapped", 5'b11000, 4'd0, 1, 1, 5'd0, 0);
    inc  = 1'b0;
    wptr = 5'b11001;
    tick(3);
    chk_all("w17", 5'b11000, 4'd0, 0, 1, 5'd1, 0);
    wptr = 5'b11011;
    tick(2);
    chk_all("w18_sync", 5'b11000, 4'd0, 0, 1, 5'd1, 0);
    inc = 1'b1;
    tick(1);
    chk_all("simul", 5'b11001, 4'd1, 0, 1, 5'd1, 0);
    tick(1);
    chk_all("last", 5'b11011, 4'd2, 1, 1, 5'd0, 0);
    inc = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
